// File: rtl/mist_frame_monitor.sv
// VGA_VS frame counter with dump-window FSM, finish request and vsync-loss watchdog.
// Latency: frame_stb and all event strobes 3 clk after the active VS edge; pure observer, no backpressure.
module mist_frame_monitor #(
    parameter logic VS_POL = 1'b0,
    parameter int   WDOG_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              VGA_VS,
    input  logic [31:0]       dump_start,
    input  logic [31:0]       dump_len,
    input  logic [31:0]       max_frames,
    input  logic [WDOG_W-1:0] wdog_limit,
    output logic [31:0]       frame_cnt,
    output logic              frame_stb,
    output logic              dump_on,
    output logic              dump_start_stb,
    output logic              dump_stop_stb,
    output logic              finish_req,
    output logic              wdog_to,
    output logic              led
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DUMP,
        ST_DONE
    } state_t;

    localparam logic [WDOG_W-1:0] WDOG_MAX = {WDOG_W{1'b1}};
    localparam logic [WDOG_W-1:0] WDOG_ONE = {{(WDOG_W-1){1'b0}}, 1'b1};

    logic              vs_s1_q, vs_s1_d;
    logic              vs_s2_q, vs_s2_d;
    logic              vs_hist_q, vs_hist_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d;
    logic              frame_stb_q, frame_stb_d;
    logic              led_q, led_d;
    logic              finish_req_q, finish_req_d;
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_armed_q, wdog_armed_d;
    logic              wdog_to_q, wdog_to_d;
    state_t            state_q, state_d;
    logic              dump_on_q, dump_on_d;
    logic              start_stb_q, start_stb_d;
    logic              stop_stb_q, stop_stb_d;

    logic              edge_det;
    logic [31:0]       win_end;

    always_comb begin
        vs_s1_d   = VGA_VS;
        vs_s2_d   = vs_s1_q;
        vs_hist_d = vs_s2_q;
        edge_det  = VS_POL ? (vs_s2_q & ~vs_hist_q) : (~vs_s2_q & vs_hist_q);
        win_end   = dump_start + dump_len;

        frame_stb_d = edge_det;
        frame_cnt_d = frame_cnt_q;
        if (edge_det) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
        led_d = frame_cnt_d[5];

        finish_req_d = finish_req_q |
                       (edge_det && (max_frames != 32'd0) && (frame_cnt_d == max_frames));

        // Counter runs from reset but only the armed flag lets it raise a timeout.
        wdog_cnt_d = wdog_cnt_q;
        if (edge_det) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q != WDOG_MAX) begin
            wdog_cnt_d = wdog_cnt_q + WDOG_ONE;
        end
        wdog_armed_d = wdog_armed_q | edge_det;
        wdog_to_d    = wdog_to_q |
                       (wdog_armed_q && (wdog_limit != '0) && (wdog_cnt_d == wdog_limit));
    end

    always_comb begin
        state_d     = state_q;
        start_stb_d = 1'b0;
        stop_stb_d  = 1'b0;
        dump_on_d   = (state_q == ST_DUMP);
        case (state_q)
            ST_IDLE: begin
                state_d = (dump_len != 32'd0) ? ST_WAIT : ST_DONE;
            end
            ST_WAIT: begin
                if ((dump_start == 32'd0) || (edge_det && (frame_cnt_d == dump_start))) begin
                    state_d     = ST_DUMP;
                    start_stb_d = 1'b1;
                end
            end
            ST_DUMP: begin
                // A finish request closes an open window so the dump is never left dangling.
                if ((edge_det && (frame_cnt_d == win_end)) || finish_req_d) begin
                    state_d    = ST_DONE;
                    stop_stb_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1_q      <= 1'b0;
            vs_s2_q      <= 1'b0;
            vs_hist_q    <= 1'b0;
            frame_cnt_q  <= 32'd0;
            frame_stb_q  <= 1'b0;
            led_q        <= 1'b0;
            finish_req_q <= 1'b0;
            wdog_cnt_q   <= '0;
            wdog_armed_q <= 1'b0;
            wdog_to_q    <= 1'b0;
            state_q      <= ST_IDLE;
            dump_on_q    <= 1'b0;
            start_stb_q  <= 1'b0;
            stop_stb_q   <= 1'b0;
        end else begin
            vs_s1_q      <= vs_s1_d;
            vs_s2_q      <= vs_s2_d;
            vs_hist_q    <= vs_hist_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_stb_q  <= frame_stb_d;
            led_q        <= led_d;
            finish_req_q <= finish_req_d;
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_armed_q <= wdog_armed_d;
            wdog_to_q    <= wdog_to_d;
            state_q      <= state_d;
            dump_on_q    <= dump_on_d;
            start_stb_q  <= start_stb_d;
            stop_stb_q   <= stop_stb_d;
        end
    end

    assign frame_cnt      = frame_cnt_q;
    assign frame_stb      = frame_stb_q;
    assign dump_on        = dump_on_q;
    assign dump_start_stb = start_stb_q;
    assign dump_stop_stb  = stop_stb_q;
    assign finish_req     = finish_req_q;
    assign wdog_to        = wdog_to_q;
    assign led            = led_q;

endmodule

// File: doc/mist_frame_monitor.md
Name: mist_frame_monitor

Overview:
- Produces the frame count, dump-window strobes and finish request that the simulation dump controller consumes.
- Sits between the video timing output (VGA_VS) of the MiST top level and the dump/trace logic in the game testbench.
- Detects vertical-sync edges and counts frames.
- Drives a dump-window state machine and a vsync-loss watchdog so long runs can be bounded and stuck video can be reported.

Parameters:
- VS_POL, 0: VGA_VS active level (0 = active-low pulse, frame boundary on the falling edge).
- WDOG_W, 24: watchdog counter width in clocks.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- VGA_VS  input  1  vertical sync from video; asynchronous to clk.
- dump_start  input  32  first frame of the dump window.
- dump_len  input  32  dump window length in frames; 0 disables dumping.
- max_frames  input  32  frame count that requests finish; 0 disables the finish request.
- wdog_limit  input  WDOG_W  clocks allowed between frame edges; 0 disables the watchdog.
- frame_cnt  output  32  frames completed since reset.
- frame_stb  output  1  one-clock pulse per detected frame edge.
- dump_on  output  1  high while inside the dump window.
- dump_start_stb  output  1  one-clock pulse on window entry.
- dump_stop_stb  output  1  one-clock pulse on window exit.
- finish_req  output  1  sticky; set when frame_cnt reaches max_frames.
- wdog_to  output  1  sticky vsync-loss flag.
- led  output  1  heartbeat; toggles every 32 frames.

Behaviour:
- Reset: all outputs 0; frame_cnt 0; state IDLE; synchronizer flops 0.
- Synchronizer:
  - VGA_VS passes through a 2-flop synchronizer, then an edge-history flop.
  - Active edge is falling when VS_POL=0, rising when VS_POL=1.
  - frame_stb asserts 3 clocks after the input edge (2 sync + 1 detect), for exactly 1 clock.
- Frame counter:
  - On frame_stb, frame_cnt increments by 1.
  - The new value is visible in the same cycle frame_stb is high (register update coincides with the strobe).
  - Wraps from 0xFFFFFFFF to 0 without any flag.
- led: equals frame_cnt[5], registered with frame_cnt.
- Dump FSM states: IDLE, WAIT, DUMP, DONE.
  - IDLE -> WAIT on the first clock after reset if dump_len != 0; otherwise IDLE -> DONE.
  - WAIT -> DUMP on the frame_stb cycle where the new frame_cnt == dump_start. The same cycle drives dump_start_stb=1; dump_on rises one clock later.
  - If dump_start == 0: enter DUMP from WAIT on the first clock, without waiting for a frame.
  - DUMP -> DONE on the frame_stb cycle where new frame_cnt == dump_start + dump_len (32-bit wrapping add). The same cycle drives dump_stop_stb=1; dump_on falls one clock later.
  - DONE is terminal until reset.
  - If dump_start is already below frame_cnt while in WAIT, the FSM stays in WAIT until the counter wraps. No catch-up.
- Configuration inputs (dump_start, dump_len, max_frames, wdog_limit) are sampled continuously and are required to be static after reset; behaviour when they change mid-run is unspecified.
- finish_req:
  - Set on the frame_stb cycle where new frame_cnt == max_frames and max_frames != 0.
  - Sticky until reset.
  - If set while in DUMP, the FSM forces DUMP -> DONE in the same cycle and pulses dump_stop_stb, so the dump is closed.
- Watchdog:
  - Counter clears on frame_stb; otherwise increments, saturating at all-ones.
  - wdog_to sets when counter == wdog_limit and wdog_limit != 0. Sticky.
  - Disarmed until the first frame_stb after reset, so no timeout fires during initial blanking.
- Simultaneous events:
  - Window entry and exit on the same frame (only possible with dump_len wrap cases) is resolved as entry. Exit is checked from the next frame.
  - dump_stop_stb and finish_req may assert in the same cycle.
- Reset mid-operation: asynchronous clear of everything. dump_on drops immediately, with no dump_stop_stb.

Test Plan:
- VS_POL=0, VGA_VS low pulses every 1000 clk for 10 frames -> frame_cnt=10, 10 frame_stb pulses, each 3 clk after the falling edge.
- dump_start=3, dump_len=2 -> dump_start_stb on the frame_cnt=3 strobe; dump_on high for frames 3–4; dump_stop_stb on frame 5; state DONE; no further strobes.
- dump_len=0 -> dump_on never asserts, and neither strobe pulses over 20 frames.
- max_frames=4, dump_start=2, dump_len=10 -> at frame 4, finish_req=1 and dump_stop_stb=1 in the same cycle; dump_on=0 next clock.
- wdog_limit=5000, vsync stops after frame 2 -> wdog_to=1 exactly 5000 clk after the last frame_stb; stays 1 when vsync resumes.
- Assert rst_n=0 during DUMP at frame 6 -> all outputs 0 asynchronously; after release, frame_cnt restarts from 0 and the window is re-entered at dump_start.
